divu_arbiter: RTL and testbench
===============================

// Module: divu_arbiter
// PURPOSE
//  Shares one sequential N-bit unsigned divider (divu256) between NREQ requesters.
//  Round-robin grant per operation; one operation in flight at a time.
//  Sequences divider start/run via div_go, captures result on div_rdy, returns tagged response.
//  Zero-divisor requests bypass the divider; a watchdog bounds a hung divider.
// PARAMETERS
//  N        256   operand/result width (bits)
//  NREQ     4     number of requesters (>=2)
//  IDW      2     response id width, = $clog2(NREQ)
//  TIMEOUT  600   WAIT-state cycle limit before timeout response (> divider latency ~N+4)
// PORTS
//  clk       in   1         clock, all logic on posedge
//  rst       in   1         synchronous, active-high reset
//  req_valid in   NREQ      per-requester request valid
//  req_ready out  NREQ      one-hot 1-cycle accept pulse
//  req_divd  in   NREQ*N    dividends, requester i at [i*N +: N]
//  req_dvsr  in   NREQ*N    divisors, same packing
//  rsp_valid out  1         response valid
//  rsp_ready in   1         response consumer ready
//  rsp_id    out  IDW       requester index of response
//  rsp_val   out  N         quotient
//  rsp_rem   out  N         remainder
//  rsp_dbz   out  1         divide-by-zero flag
//  rsp_tmo   out  1         divider timeout flag
//  div_go    out  1         divider run; high = run, low = divider held idle/cleared
//  div_divd  out  N         registered dividend to divider
//  div_dvsr  out  N         registered divisor to divider
//  div_val   in   N         divider quotient
//  div_rem   in   N         divider remainder
//  div_dbz   in   1         divider dbz flag
//  div_rdy   in   1         divider result valid
//  busy      out  1         high in any state other than IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; rr pointer last=NREQ-1 (requester 0 highest first).
//  rst mid-operation: next cycle IDLE, div_go=0, no response emitted, in-flight op dropped.
//  Requester rule: hold req_valid and operands stable until req_ready pulse.
//  FSM IDLE/ISSUE/WAIT/RESP:
//   IDLE: if any req_valid, g = first valid at (last+1..last+NREQ) mod NREQ.
//     Same cycle: req_ready[g]=1, latch operands and id, last<=g.
//     If dvsr==0 -> RESP with dbz=1, val=0, rem=0, tmo=0 (div_go never raised).
//     Else -> ISSUE. No valid -> stay.
//   ISSUE: div_go=1, wdog<=0 -> WAIT (1 cycle).
//   WAIT: div_go=1, wdog++. div_rdy ignored while wdog<2 (stale result guard).
//     div_rdy && wdog>=2: capture val/rem/dbz, tmo=0 -> RESP, div_go=0 next cycle.
//     wdog==TIMEOUT-1 without rdy: val=rem=0, dbz=0, tmo=1 -> RESP.
//   RESP: rsp_valid=1, all rsp_* stable while rsp_ready=0; div_go=0.
//     rsp_valid&&rsp_ready -> IDLE; new grant no earlier than the following cycle.
//  div_go low >=2 cycles between operations (RESP + IDLE) so divider reinitialises.
//  Latency: accept to rsp_valid = divider latency + 2 cycles; dbz bypass = 1 cycle.
//  Fairness: any continuously valid requester is granted within NREQ operations.
//  div_divd/div_dvsr change only on grant; stable through ISSUE/WAIT.
// TESTING
//  T1 req0 12/5, rsp_ready=1 -> rsp id0 val=2 rem=2 dbz=0 tmo=0; req_ready[0] exactly 1 cycle.
//  T2 req0 and req2 valid same cycle (45/9, 5/7) -> id0 (5,0) then id2 (0,5).
//  T3 all 4 valid, each re-requesting on accept -> grant order 0,1,2,3,0,1; never repeats early.
//  T4 req1 100/0 -> rsp 1 cycle after accept, dbz=1 val=0 rem=0; div_go stays 0.
//  T5 rsp_ready low 50 cycles, others valid -> rsp_* stable, no req_ready pulse, busy=1.
//  T6 stub divider never raises div_rdy -> tmo=1 exactly TIMEOUT cycles after ISSUE.
//  T7 rst high 1 cycle mid-WAIT (all-ones/all-ones) -> div_go=0, no rsp; next req1 granted first.

Source files
------------

// File: rtl/divu_arbiter.sv
// divu_arbiter: shares one sequential N-bit unsigned divider between NREQ
// requesters. Grants one operation at a time in round-robin order, sequences the
// divider through div_go and returns a response tagged with the requester id.
// Divide-by-zero requests are answered without touching the divider. A watchdog
// answers with a timeout flag if the divider never reports a result.
//
// Ports
//   clk, rst            clock (posedge), synchronous active-high reset
//   req_valid[NREQ]     per-requester request valid
//   req_ready[NREQ]     one-hot, single-cycle accept pulse
//   req_divd/req_dvsr   packed operands, requester i at [i*N +: N]
//   rsp_valid/rsp_ready response handshake
//   rsp_id/val/rem      requester index, quotient, remainder
//   rsp_dbz/rsp_tmo     divide-by-zero flag, divider timeout flag
//   div_go              divider run (low = divider held idle / cleared)
//   div_divd/div_dvsr   registered operands to the divider
//   div_val/rem/dbz/rdy divider result and result-valid
//   busy                high whenever the arbiter is not idle
//   state_dbg           current FSM state encoding
//
// Handshakes: a transfer happens on a clock edge where valid and ready are both
// high. Requesters hold req_valid and operands stable until their req_ready
// pulse; rsp_* is held stable while rsp_valid is high and rsp_ready is low.
module divu_arbiter #(
  parameter int N       = 256,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 600
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_divd,
  input  logic [NREQ*N-1:0] req_dvsr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_val,
  output logic [N-1:0]      rsp_rem,
  output logic              rsp_dbz,
  output logic              rsp_tmo,
  output logic              div_go,
  output logic [N-1:0]      div_divd,
  output logic [N-1:0]      div_dvsr,
  input  logic [N-1:0]      div_val,
  input  logic [N-1:0]      div_rem,
  input  logic              div_dbz,
  input  logic              div_rdy,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  last;
  logic [WW-1:0]   wdog;
  logic [IDW-1:0]  id_q;
  logic [N-1:0]    divd_q, dvsr_q, val_q, rem_q;
  logic            dbz_q, tmo_q;

  logic            gnt_found;
  logic [IDW-1:0]  gnt_idx;
  logic [N-1:0]    gnt_divd, gnt_dvsr;
  logic            wait_hit, wait_tmo;

  // Round-robin pick: the lowest valid index above 'last' wins; if there is
  // none, the lowest valid index at or below 'last' (wrap-around) wins. Both
  // loops run high-to-low so the final assignment is the lowest index, and the
  // second loop overrides the wrap-around candidate.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (IDW'(i) <= last)) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(i);
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (IDW'(i) > last)) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(i);
      end
    end
  end

  always_comb begin
    gnt_divd = '0;
    gnt_dvsr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        gnt_divd = req_divd[i*N +: N];
        gnt_dvsr = req_dvsr[i*N +: N];
      end
    end
  end

  // The divider may still present the previous operation's result for a cycle
  // or two after div_go rises, so div_rdy is only trusted from wdog==2 onward.
  assign wait_hit = div_rdy && (wdog >= WW'(2));
  assign wait_tmo = (wdog == WW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (gnt_found) begin
          state_nxt = (gnt_dvsr == '0) ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (wait_hit || wait_tmo) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      last   <= IDW'(NREQ - 1);
      wdog   <= '0;
      id_q   <= '0;
      divd_q <= '0;
      dvsr_q <= '0;
      val_q  <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (gnt_found) begin
            id_q   <= gnt_idx;
            last   <= gnt_idx;
            divd_q <= gnt_divd;
            dvsr_q <= gnt_dvsr;
            val_q  <= '0;
            rem_q  <= '0;
            dbz_q  <= (gnt_dvsr == '0);
            tmo_q  <= 1'b0;
          end
        end
        ST_ISSUE: wdog <= '0;
        ST_WAIT: begin
          wdog <= wdog + WW'(1);
          if (wait_hit) begin
            val_q <= div_val;
            rem_q <= div_rem;
            dbz_q <= div_dbz;
            tmo_q <= 1'b0;
          end else if (wait_tmo) begin
            val_q <= '0;
            rem_q <= '0;
            dbz_q <= 1'b0;
            tmo_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Reset forces req_ready low even though it is combinational from req_valid.
  assign req_ready = (state == ST_IDLE && !rst && gnt_found) ?
                     (NREQ'(1) << gnt_idx) : '0;

  assign div_go    = (state == ST_ISSUE) || (state == ST_WAIT);
  assign div_divd  = divd_q;
  assign div_dvsr  = dvsr_q;
  assign rsp_valid = (state == ST_RESP);
  assign rsp_id    = id_q;
  assign rsp_val   = val_q;
  assign rsp_rem   = rem_q;
  assign rsp_dbz   = dbz_q;
  assign rsp_tmo   = tmo_q;
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_divu_arbiter.sv
`timescale 1ns/1ps
module tb_divu_arbiter;
  localparam int N       = 256;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 64;
  localparam int EW      = IDW + 2*N + 2;   // {id, val, rem, dbz, tmo}
  localparam int OW      = IDW + 2*N;       // {id, divd, dvsr}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*N-1:0] req_divd, req_dvsr;
  logic              rsp_valid, rsp_ready, rsp_dbz, rsp_tmo;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_val, rsp_rem;
  logic              div_go, div_dbz, div_rdy, busy;
  logic [N-1:0]      div_divd, div_dvsr, div_val, div_rem;
  logic [1:0]        state_dbg;

  divu_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_divd(req_divd), .req_dvsr(req_dvsr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_val(rsp_val), .rsp_rem(rsp_rem), .rsp_dbz(rsp_dbz), .rsp_tmo(rsp_tmo),
    .div_go(div_go), .div_divd(div_divd), .div_dvsr(div_dvsr),
    .div_val(div_val), .div_rem(div_rem), .div_dbz(div_dbz), .div_rdy(div_rdy),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- bench state ----------------
  int checks = 0;
  int passed = 0;
  logic [EW-1:0] exp_q[$];
  int            lat_q[$];
  logic [OW-1:0] op_q[$];
  int            glog[$];
  int            gcount = 0;
  int            rsp_mode = 1;      // 0 random, 1 always ready, 2 never ready
  logic          hang_mode = 1'b0;  // stub divider never raises div_rdy
  logic          stale_mode = 1'b0; // stub shows a stale result early in the run
  int            stub_lat = 8;
  int            stub_cnt = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [N-1:0] rand_n();
    logic [N-1:0] v;
    for (int i = 0; i < N/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- stub divider ----------------
  // Result is reported stub_lat cycles after div_go rises (counting the first
  // div_go cycle as 0). In stale mode it also shows a bogus result early on.
  always @(posedge clk) stub_cnt <= div_go ? stub_cnt + 1 : 0;

  always_comb begin
    div_rdy = 1'b0;
    div_val = '1;
    div_rem = '1;
    div_dbz = 1'b1;
    if (div_go && !hang_mode) begin
      if (stub_cnt == stub_lat && div_dvsr != '0) begin
        div_rdy = 1'b1;
        div_val = div_divd / div_dvsr;
        div_rem = div_divd % div_dvsr;
        div_dbz = 1'b0;
      end else if (stale_mode && stub_cnt <= 2) begin
        div_rdy = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_op(input int id, input logic [N-1:0] a, input logic [N-1:0] b);
    op_q.push_back({IDW'(id), a, b});
  endtask

  task automatic present();
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < op_q.size(); j++) begin
        if (int'(op_q[j][2*N +: IDW]) == i) begin
          req_valid[i]        = 1'b1;
          req_divd[i*N +: N]  = op_q[j][N +: N];
          req_dvsr[i*N +: N]  = op_q[j][0 +: N];
          break;
        end
      end
    end
  endtask

  initial begin : drv
    logic [NREQ-1:0] rdy_s;
    req_valid = '0;
    req_divd  = '0;
    req_dvsr  = '0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      rdy_s = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (rdy_s[i]) begin
          for (int j = 0; j < op_q.size(); j++) begin
            if (int'(op_q[j][2*N +: IDW]) == i) begin
              op_q.delete(j);
              break;
            end
          end
        end
      end
      present();
      case (rsp_mode)
        0:       rsp_ready = ($urandom_range(0, 3) != 0);
        1:       rsp_ready = 1'b1;
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor + reference model ----------------
  initial begin : mon
    int            cyc, acc_cyc, out_cnt, last_m, low_run, g;
    logic          prev_rv, prev_go, hold_v, go_seen;
    logic [EW-1:0] held, cur, e;
    logic [NREQ-1:0] oh;
    logic [N-1:0]  a, b;
    cyc = 0; acc_cyc = 0; out_cnt = 0; last_m = NREQ - 1; low_run = 2;
    prev_rv = 1'b0; prev_go = 1'b0; hold_v = 1'b0; go_seen = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete(); lat_q.delete();
        out_cnt = 0; last_m = NREQ - 1; low_run = 2;
        prev_rv = 1'b0; prev_go = 1'b0; hold_v = 1'b0;
        continue;
      end
      // grant: round-robin from the model's own pointer
      if (req_ready != '0) begin
        g = -1;
        for (int k = 1; k <= NREQ; k++) begin
          if (g < 0 && req_valid[(last_m + k) % NREQ]) g = (last_m + k) % NREQ;
        end
        if (g < 0) begin
          check("grant_without_valid", N'(req_ready), '0);
          g = 0;
        end else begin
          oh = '0;
          oh[g] = 1'b1;
          check("grant", N'(req_ready), N'(oh));
        end
        check("grant_while_busy", N'(out_cnt), '0);
        a = req_divd[g*N +: N];
        b = req_dvsr[g*N +: N];
        if (b == '0) begin
          exp_q.push_back({IDW'(g), {N{1'b0}}, {N{1'b0}}, 1'b1, 1'b0});
          lat_q.push_back(1);
        end else if (hang_mode) begin
          exp_q.push_back({IDW'(g), {N{1'b0}}, {N{1'b0}}, 1'b0, 1'b1});
          lat_q.push_back(TIMEOUT + 2);
        end else begin
          stub_lat   = $urandom_range(4, 20);
          stale_mode = 1'($urandom_range(0, 1));
          exp_q.push_back({IDW'(g), a / b, a % b, 1'b0, 1'b0});
          lat_q.push_back(stub_lat + 2);
        end
        last_m = g;
        acc_cyc = cyc;
        out_cnt++;
        go_seen = 1'b0;
        glog.push_back(g);
        gcount++;
      end
      // divider run tracking
      if (div_go) begin
        if (!prev_go) check("go_low_gap", N'(low_run >= 2), 1);
        go_seen = 1'b1;
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_go = div_go;
      // response
      cur = {rsp_id, rsp_val, rsp_rem, rsp_dbz, rsp_tmo};
      if (hold_v && !rsp_valid) check("rsp_dropped", N'(rsp_valid), 1);
      if (rsp_valid) begin
        if (!prev_rv) begin
          if (lat_q.size() == 0) check("rsp_no_request", N'(rsp_valid), 0);
          else check("latency", N'(cyc - acc_cyc), N'(lat_q[0]));
        end
        if (hold_v) check("rsp_stable", N'(cur != held), 0);
        if (rsp_ready) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", N'(rsp_valid), 0);
          end else begin
            e = exp_q.pop_front();
            if (lat_q.size() > 0) lat_q.delete(0);
            check("rsp_id",  N'(rsp_id),  N'(e[2*N+2 +: IDW]));
            check("rsp_val", rsp_val, e[N+2 +: N]);
            check("rsp_rem", rsp_rem, e[2 +: N]);
            check("rsp_dbz_tmo", N'({rsp_dbz, rsp_tmo}), N'(e[1:0]));
            check("div_go_used", N'(go_seen), N'(!e[1]));
            out_cnt--;
          end
          hold_v = 1'b0;
        end else begin
          hold_v = 1'b1;
          held   = cur;
        end
      end else begin
        hold_v = 1'b0;
      end
      prev_rv = rsp_valid;
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic wait_idle(input int budget);
    int n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      done = (op_q.size() == 0) && (exp_q.size() == 0) && !busy && !rsp_valid;
    end
    check("drain", N'(done), 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic check_glog(input string name, input int exp_ids[$]);
    check({name, "_count"}, N'(glog.size()), N'(exp_ids.size()));
    for (int i = 0; i < exp_ids.size() && i < glog.size(); i++)
      check(name, N'(glog[i]), N'(exp_ids[i]));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation exceeded 50000 cycles");
    $fatal(1);
  end

  // ---------------- tests ----------------
  initial begin : test
    int g0, n, run;
    logic [N-1:0] a, b;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", N'(req_ready), '0);
    check("rst_rsp_valid", N'(rsp_valid), '0);
    check("rst_busy",      N'(busy), '0);
    check("rst_div_go",    N'(div_go), '0);
    check("rst_rsp_val",   rsp_val, '0);
    check("rst_rsp_rem",   rsp_rem, '0);
    check("rst_div_ops",   div_divd | div_dvsr, '0);
    check("rst_rsp_flags", N'({rsp_id, rsp_dbz, rsp_tmo}), '0);
    @(posedge clk); #1 rst = 1'b0;

    // T1: single op 12/5
    g0 = gcount;
    push_op(0, N'(12), N'(5));
    wait_idle(200);
    check("t1_pulses", N'(gcount - g0), 1);

    // T2: req0 and req2 together, from reset
    do_reset();
    glog.delete();
    push_op(0, N'(45), N'(9));
    push_op(2, N'(5), N'(7));
    wait_idle(300);
    check_glog("t2_order", '{0, 2});

    // T3: all four valid, each re-requesting once on accept
    do_reset();
    glog.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++)
        push_op(i, rand_n(), rand_n() >> $urandom_range(0, 250));
    wait_idle(800);
    check_glog("t3_order", '{0, 1, 2, 3, 0, 1, 2, 3});

    // T4: divide by zero bypass
    push_op(1, N'(100), '0);
    wait_idle(100);

    // T5: consumer stalls for 50 cycles while others are waiting
    rsp_mode = 2;
    for (int i = 0; i < NREQ; i++) push_op(i, rand_n(), N'($urandom_range(1, 1000)));
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_rsp_seen", N'(rsp_valid), 1);
    g0 = gcount;
    repeat (50) begin
      @(negedge clk);
      check("t5_busy",      N'(busy), 1);
      check("t5_rsp_valid", N'(rsp_valid), 1);
      check("t5_no_ready",  N'(req_ready), '0);
    end
    check("t5_no_grant", N'(gcount - g0), 0);
    rsp_mode = 0;
    wait_idle(800);

    // T6: hung divider -> timeout response
    rsp_mode = 1;
    hang_mode = 1'b1;
    push_op(3, rand_n(), N'($urandom_range(1, 99)));
    wait_idle(TIMEOUT + 50);
    hang_mode = 1'b0;

    // T7: reset in the middle of WAIT, requesters 1 and 2 waiting
    hang_mode = 1'b1;
    push_op(0, '1, '1);
    run = 0;
    n = 0;
    while (run < 5 && n < 100) begin
      @(negedge clk);
      n++;
      run = div_go ? run + 1 : 0;
    end
    check("t7_in_wait", N'(run >= 5), 1);
    push_op(1, N'(7), N'(3));
    push_op(2, N'(9), N'(2));
    glog.delete();
    @(posedge clk); #1 rst = 1'b1; hang_mode = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t7_div_go",    N'(div_go), '0);
    check("t7_rsp_valid", N'(rsp_valid), '0);
    check("t7_busy",      N'(busy), '0);
    wait_idle(300);
    check_glog("t7_order", '{1, 2});

    // Random traffic with a random consumer
    rsp_mode = 0;
    for (int k = 0; k < 12; k++) begin
      for (int m = 0; m < $urandom_range(1, 4); m++) begin
        a = rand_n();
        case ($urandom_range(0, 3))
          0:       b = '0;
          1:       b = N'($urandom_range(1, 255));
          2:       b = rand_n() >> $urandom_range(1, 255);
          default: b = rand_n();
        endcase
        if (b == '0 && $urandom_range(0, 1) == 1) b = N'(1);
        push_op($urandom_range(0, NREQ - 1), a, b);
      end
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    wait_idle(4000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
